// File: rtl/wide_add_pkg.sv
// wide_add_pkg: shared types and constants for the byte-serial wide adder.
package wide_add_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} wa_state_e;
    localparam int BYTE_W = 8;
    localparam int NBYTES_MAX = 16;
endpackage

// File: rtl/wide_add_sequencer_csa8.sv
// carry_select_adder8: 8-bit adder, low nibble ripples, high nibble precomputed for both carries.
module carry_select_adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    logic [4:0] lo, hi0, hi1;
    assign lo = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
    assign hi0 = {1'b0, a[7:4]} + {1'b0, b[7:4]};
    assign hi1 = hi0 + 5'd1;
    assign {cout, sum} = {lo[4] ? hi1 : hi0, lo[3:0]};
endmodule

// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: streams wide operands one byte per cycle through carry_select_adder8.
// Define WIDE_ADD_SEQUENCER_SUBTRACT_EN to add the in_sub port (A-B via inverted B and carry-in 1).
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] in_a,
    input  logic [BYTE_W*NBYTES-1:0] in_b,
    input  logic                     in_cin,
`ifdef WIDE_ADD_SEQUENCER_SUBTRACT_EN
    input  logic                     in_sub,
`endif
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] out_sum,
    output logic                     out_cout
);
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    wa_state_e state, state_n;
    logic [NBYTES-1:0][BYTE_W-1:0] a_q, b_q, sum_q;
    logic [IW-1:0] idx;
    logic carry_q, cout_q, valid_q, last, sub;
    logic [BYTE_W-1:0] add_s;
    logic add_c;
`ifdef WIDE_ADD_SEQUENCER_SUBTRACT_EN
    assign sub = in_sub;
`else
    assign sub = 1'b0;
`endif
    assign last = idx == IW'(NBYTES - 1);
    assign in_ready = state == IDLE;
    assign out_valid = valid_q;
    assign out_sum = sum_q;
    assign out_cout = cout_q;

    carry_select_adder8 u_add (
        .a   (a_q[idx]),
        .b   (b_q[idx]),
        .cin (carry_q),
        .sum (add_s),
        .cout(add_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (in_valid ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            sum_q <= '0;
            idx <= '0;
            carry_q <= 1'b0;
            cout_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_q <= in_a;
                b_q <= sub ? ~in_b : in_b;
                carry_q <= sub | in_cin;
                idx <= '0;
                sum_q <= '0;
                cout_q <= 1'b0;
            end
        end else if (state == RUN) begin
            sum_q[idx] <= add_s;
            carry_q <= add_c;
            // idx stops on the last byte so it never wraps
            if (!last) idx <= idx + 1'b1;
            if (last) begin
                cout_q <= add_c;
                valid_q <= 1'b1;
            end
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end
endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-byte adder front end that streams wide operands one byte per cycle through the existing 8-bit carry-select adder, registering the carry between byte slices. It sits directly upstream of `carry_select_adder8`: it drives the adder's a/b/cin each cycle, consumes its sum/cout, and assembles the wide result. Operands enter and results leave on valid/ready handshakes, so the block slots into pipelines that need sums wider than 8 bits without a wide combinational carry chain.

## Interface

**Parameters**
- `NBYTES`, default 4: operand width in bytes. Legal range 1..16.

**Ports**
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts an operand beat; equals (state==IDLE).
- `in_a` in 8*NBYTES: operand A.
- `in_b` in 8*NBYTES: operand B.
- `in_cin` in 1: carry into byte 0.
- `in_sub` in 1: 1 selects A−B. Present only with SUBTRACT_EN.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_sum` out 8*NBYTES: wide sum.
- `out_cout` out 1: carry out of the top byte. Under subtract, 1 means no borrow.

## Operation

- FSM states: IDLE, RUN, DONE.
  - IDLE: `in_ready`=1. When `in_valid`=1, capture `in_a`, `in_b`, `in_cin` (and `in_sub`). Set idx←0, carry_q←`in_cin`, clear the result register, go to RUN.
  - RUN: drive the adder with a=A[8*idx+:8], b=B[8*idx+:8], cin=carry_q.
    - Write the adder sum into result byte idx. Set carry_q←cout, idx←idx+1.
    - When idx==NBYTES-1, go to DONE.
  - DONE: `out_valid`=1, and `out_sum`/`out_cout` are held stable. When `out_ready`=1, go to IDLE.
- `in_valid` is ignored outside IDLE. `out_ready` is ignored outside DONE.
- Arithmetic: `out_sum` = (A + B + cin) mod 2^(8·NBYTES). `out_cout` = bit 8·NBYTES of the full sum.
- idx width is $clog2(NBYTES) with a minimum of 1 bit. idx never wraps, because the exit test is the last byte.
- NBYTES=1: RUN lasts exactly one cycle.
- Operand registers are frozen from capture until the return to IDLE.

## Timing

- Reset (`rst_n`=0 at an edge): state=IDLE, `out_valid`=0, `out_sum`=0, `out_cout`=0, carry_q=0, idx=0. `in_ready`=1 in the first cycle after release.
- Reset mid-RUN or mid-DONE aborts the operation. The next cycle shows IDLE with all outputs at their reset values, and the partial result is discarded.
- Latency: the accept happens in cycle 0. RUN occupies cycles 1..NBYTES. `out_valid` rises in cycle NBYTES+1.
- Throughput: with `out_ready` tied high, one operation every NBYTES+2 cycles. This is 6 cycles for NBYTES=4.
- The adder path is combinational within a single RUN cycle. All outputs are registered except `in_ready`, which is decoded from state.

## Configuration

- `WIDE_ADD_SEQUENCER_SUBTRACT_EN` defined:
  - The `in_sub` port exists.
  - When `in_sub`=1 at capture, B is stored inverted and carry_q←1, with `in_cin` ignored. The result is A−B.
  - `out_cout`=1 indicates A≥B unsigned.
- Not defined: the `in_sub` port is absent and the block always adds.

## Structure

- Package `wide_add_pkg`:
  - state enum `wa_state_e` {IDLE, RUN, DONE}
  - `BYTE_W`=8
  - `NBYTES_MAX`=16
- Sub-module: one instance of `carry_select_adder8`, used unmodified. The FSM, byte muxing and result register stay in `wide_add_sequencer`.

## Test plan

All scenarios use NBYTES=4.

1. **Byte carry propagation:** A=0x000000FF, B=0x00000001, cin=0 → `out_sum`=0x00000100, `out_cout`=0. `out_valid` rises in cycle 5 after the accept.
2. **Full ripple through all bytes:** A=0xFFFFFFFF, B=0x00000000, cin=1 → `out_sum`=0x00000000, `out_cout`=1.
3. **Backpressure:** A=0x12345678, B=0x11111111, `out_ready` low for 5 cycles in DONE → `out_sum` held at 0x23456789 and `in_ready`=0 throughout. A new `in_valid` pulse is ignored. The result completes on the first `out_ready`=1.
4. **Reset mid-operation:** assert `rst_n`=0 during RUN with idx=2 → the next cycle shows IDLE, `out_valid`=0, `out_sum`=0, `in_ready`=1 after release. The following operation 1+1 → 0x00000002.
5. **Subtract, macro defined:** A=0x00000010, B=0x00000011, `in_sub`=1 → `out_sum`=0xFFFFFFFF, `out_cout`=0. A=0x20, B=0x10 → `out_sum`=0x00000010, `out_cout`=1.
6. **Back-to-back throughput:** `in_valid` and `out_ready` held high for 3 operations → accepts occur in cycles 0, 6 and 12, with every result correct.
